serial_lut_loader: RTL and testbench
====================================

// Module: serial_lut_loader
// PURPOSE
//  Sequencer that loads a serial-load LUT's configuration shift register from parallel table words.
//  Accepts words over a valid/ready handshake and drives the LUT's serial data and active-low chip select.
//  Sits between the host/config path and the LUT; one load = one complete table.
//  Both blocks share one clock; the LUT shifts {table, d} on every edge where cs_n is low.
// PARAMETERS
//  IN_WIDTH   4  LUT select width; the table holds 2**IN_WIDTH entries
//  OUT_WIDTH  4  LUT entry width
//  WORD_W     8  width of the input word; TBL_BITS = 2**IN_WIDTH*OUT_WIDTH (64) must be divisible by WORD_W
//  derived: NWORDS = TBL_BITS/WORD_W (8)
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  rst_n      in   1       reset, asynchronous assert, active-low
//  start      in   1       begin a load; sampled in IDLE only
//  abort      in   1       cancel the load in progress
//  word_in    in   WORD_W  table word; word 0 = table bits [TBL_BITS-1 -: WORD_W], then descending
//  word_valid in   1       word_in valid
//  word_ready out  1       loader can accept a word this cycle
//  lut_d      out  1       serial data to the LUT (registered)
//  lut_cs_n   out  1       LUT shift enable, active-low (registered)
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse: full table shifted
//  crc        out  8       present only with SLL_CRC_EN
// BEHAVIOUR
//  Reset values: word_ready=0, lut_d=0, lut_cs_n=1, busy=0, done=0, crc=0, state=IDLE, counters=0.
//  States:
//   IDLE -> WAIT_WORD when start=1 and abort=0.
//   WAIT_WORD: word_ready=1 and lut_cs_n=1.
//    On word_valid&&word_ready: load the word into the serializer, bit_cnt=0, go to SHIFT.
//   SHIFT: exactly WORD_W cycles with lut_cs_n=0; lut_d = current word MSB-first.
//    After bit WORD_W-1: if word_cnt==NWORDS-1 go to DONE, else increment word_cnt and go to WAIT_WORD.
//   DONE: done=1 for one cycle, lut_cs_n=1, then IDLE.
//  Each word costs 1+WORD_W cycles.
//   With word_valid held high and start in cycle 0:
//    word k is accepted in cycle 1+(WORD_W+1)*k;
//    lut_cs_n is low in cycles 2+9k..9+9k;
//    done is high in cycle 73 (defaults).
//  Bit order: the first bit shifted is table bit TBL_BITS-1.
//   After the load, LUT entry i = original table bits [(i+1)*OUT_WIDTH-1 -: OUT_WIDTH].
//  word_valid low in WAIT_WORD: stall with lut_cs_n=1; the LUT contents hold; no timeout.
//  start while busy is ignored.
//  abort in any non-IDLE state: IDLE on the next edge; lut_cs_n=1 and word_ready=0 from that cycle.
//   done does not pulse; the partial table stays in the LUT and the caller must reload.
//  abort and start in the same cycle in IDLE: abort wins and the loader stays IDLE.
//  abort on the word_valid&&word_ready edge: the word is consumed and dropped.
//  Async reset mid-load: all outputs return to reset values immediately; lut_cs_n=1 so no spurious shift.
//  Counters: bit_cnt is $clog2(WORD_W) wide, word_cnt is $clog2(NWORDS) wide (min 1 bit). Neither wraps across a load; both clear on start.
// CONFIGURATION
//  SLL_CRC_EN defined:
//   crc is a CRC-8, poly 0x07, init 0x00, over the bits in shift order, updated on each cycle with lut_cs_n=0.
//   crc clears when start is accepted and is stable/valid from the done cycle until the next start.
//  SLL_CRC_EN undefined: no crc port and no CRC logic.
// STRUCTURE
//  Package serial_lut_pkg holds:
//   state enum {IDLE, WAIT_WORD, SHIFT, DONE};
//   function tbl_bits(in_w, out_w);
//   localparam CRC8_POLY = 8'h07.
//  Sub-module lut_word_serializer: WORD_W parallel-in/serial-out register with load, shift and msb output.
//  FSM, counters and CRC live in the top.
// TESTING
//  1 Load the table where entry i = i (words 8'hFE, 8'hDC, ..., 8'h10), word_valid always high -> done in cycle 73; a LUT model then returns out==sel for all 16 sel.
//  2 Drop word_valid for 5 cycles before word 3 -> lut_cs_n=1 and word_ready=1 during the stall; done is 5 cycles late; table correct.
//  3 Assert abort in cycle 30 (mid-SHIFT) -> lut_cs_n=1 and busy=0 from cycle 31; no done; a following full load gives the correct table.
//  4 Pulse start at cycles 0 and 10 -> the second start is ignored; exactly one done, in cycle 73.
//  5 Deassert rst_n mid-SHIFT -> lut_cs_n=1, busy=0, done=0 asynchronously; LUT receives no extra shift.
//  6 SLL_CRC_EN, all-zero table -> crc==8'h00 at done; table with entry i = i -> crc equals the reference model's CRC-8 over the 64 bits.

Source files
------------

// File: rtl/serial_lut_pkg.sv
// Shared types and helpers for the serial LUT loader: FSM state encoding,
// table-size helper and the CRC-8 polynomial.
package serial_lut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    SHIFT,
    DONE
  } sll_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  function automatic int tbl_bits(input int in_w, input int out_w);
    return (1 << in_w) * out_w;
  endfunction

endpackage

// File: rtl/lut_word_serializer.sv
// Parallel-in/serial-out register: loads one table word and presents it MSB-first,
// one bit per shift.
module lut_word_serializer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] word_in,
  output logic              msb
);

  logic [WORD_W-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= word_in;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[WORD_W-1];

endmodule

// File: rtl/serial_lut_loader.sv
// Streams a complete LUT table, word by word, into a serial-load LUT (d + active-low cs).
// Define SLL_CRC_EN to add a CRC-8 (poly 0x07) over the shifted bitstream on port crc.
module serial_lut_loader
  import serial_lut_pkg::*;
#(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              lut_d,
  output logic              lut_cs_n,
  output logic              busy,
  output logic              done
`ifdef SLL_CRC_EN
  ,
  output logic [7:0]        crc
`endif
);

  localparam int TBL_BITS = tbl_bits(IN_WIDTH, OUT_WIDTH);
  localparam int NWORDS   = TBL_BITS / WORD_W;
  localparam int BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int WCNT_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);

  sll_state_t        state, next_state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WCNT_W-1:0] word_cnt;
  logic              start_accept;
  logic              accept;
  logic              last_bit;

  assign start_accept = (state == IDLE) && start && !abort;
  assign accept       = word_valid && word_ready;
  assign last_bit     = (bit_cnt == LAST_BIT);
  assign word_ready   = (state == WAIT_WORD);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort beats everything, including a word handshake in the same cycle
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (start_accept) next_state = WAIT_WORD;
      WAIT_WORD: begin
        if (abort)           next_state = IDLE;
        else if (word_valid) next_state = SHIFT;
      end
      SHIFT: begin
        if (abort)         next_state = IDLE;
        else if (last_bit) next_state = (word_cnt == LAST_WORD) ? DONE : WAIT_WORD;
      end
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (start_accept) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      if (!last_bit) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else if (word_cnt != LAST_WORD) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // cs_n is registered from the next state so it lines up with the serializer's msb
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_cs_n <= 1'b1;
    end else begin
      lut_cs_n <= (next_state != SHIFT);
    end
  end

  lut_word_serializer #(
    .WORD_W (WORD_W)
  ) u_serializer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .shift   (state == SHIFT),
    .word_in (word_in),
    .msb     (lut_d)
  );

`ifdef SLL_CRC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (start_accept) begin
      crc <= 8'h00;
    end else if (!lut_cs_n) begin
      crc <= {crc[6:0], 1'b0} ^ ((crc[7] ^ lut_d) ? CRC8_POLY : 8'h00);
    end
  end
`endif

endmodule

// File: tb/tb_serial_lut_loader.sv
// Testbench for serial_lut_loader: models the serial LUT and checks a cycle schedule
// derived from word timing; CRC checks are active when SLL_CRC_EN is defined.
module tb_serial_lut_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] word_in;
  logic       word_valid;
  logic       word_ready;
  logic       lut_d;
  logic       lut_cs_n;
  logic       busy;
  logic       done;
`ifdef SLL_CRC_EN
  logic [7:0] crc;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] lut_sr = '0;
  int          shift_cnt = 0;

  serial_lut_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .lut_d      (lut_d),
    .lut_cs_n   (lut_cs_n),
    .busy       (busy),
    .done       (done)
`ifdef SLL_CRC_EN
    ,
    .crc        (crc)
`endif
  );

  always #5 clk = ~clk;

  // the LUT being loaded: shifts {table, d} on every edge with cs_n low
  always @(posedge clk) begin
    if (lut_cs_n === 1'b0) begin
      lut_sr    <= {lut_sr[62:0], lut_d};
      shift_cnt <= shift_cnt + 1;
    end
  end

`ifdef SLL_CRC_EN
  function automatic logic [7:0] crc8_ref(input logic [63:0] t);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < 8; b++) begin
      c = c ^ t[63-8*b -: 8];
      for (int j = 0; j < 8; j++) begin
        c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
    end
    return c;
  endfunction
`endif

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One load starting with start in cycle 0. stall_word>=0 drops word_valid for stall_len
  // cycles starting where that word would first be offered; negative cycle args disable events.
  task automatic run_load(input logic [63:0] tbl, input int stall_word, input int stall_len,
                          input int abort_cyc, input int start2_cyc, input int rst_cyc);
    int          accept_cyc[8];
    int          done_cyc, last_cyc, widx, base, exp_shifts, lo;
    logic        exp_busy, exp_done, exp_ready, exp_cs_low, exp_d, handshake;
    logic [63:0] sh;
    for (int k = 0; k < 8; k++) begin
      accept_cyc[k] = 1 + 9*k + ((stall_word >= 0 && k >= stall_word) ? stall_len : 0);
    end
    done_cyc   = accept_cyc[7] + 9;
    last_cyc   = done_cyc + 3;
    widx       = 0;
    base       = shift_cnt;
    exp_shifts = 0;
    for (int c = 0; c <= last_cyc; c++) begin
      start      = (c == 0) || (c == start2_cyc);
      abort      = (c == abort_cyc);
      word_valid = !(stall_word >= 0 && c >= 1 + 9*stall_word && c < 1 + 9*stall_word + stall_len);
      sh         = tbl << (8*widx);
      word_in    = (widx < 8) ? sh[63:56] : 8'h00;
      @(negedge clk);
      exp_busy   = (c >= 1) && (c <= done_cyc);
      exp_done   = (c == done_cyc);
      exp_ready  = 1'b0;
      exp_cs_low = 1'b0;
      exp_d      = 1'b0;
      for (int k = 0; k < 8; k++) begin
        lo = (k == 0) ? 1 : accept_cyc[k-1] + 9;
        if (c >= lo && c <= accept_cyc[k]) exp_ready = 1'b1;
        if (c >= accept_cyc[k] + 1 && c <= accept_cyc[k] + 8) begin
          exp_cs_low = 1'b1;
          exp_d      = tbl[63 - 8*k - (c - accept_cyc[k] - 1)];
        end
      end
      if (abort_cyc >= 0 && c > abort_cyc) begin
        exp_busy = 1'b0; exp_done = 1'b0; exp_ready = 1'b0; exp_cs_low = 1'b0;
      end
      check_output($sformatf("cyc%0d busy/done/ready/cs_n", c),
                   64'({busy, done, word_ready, lut_cs_n}),
                   64'({exp_busy, exp_done, exp_ready, !exp_cs_low}));
      if (exp_cs_low) check_output($sformatf("cyc%0d lut_d", c), 64'(lut_d), 64'(exp_d));
`ifdef SLL_CRC_EN
      if (exp_done) check_output("crc at done", 64'(crc), 64'(crc8_ref(tbl)));
`endif
      if (c == rst_cyc) begin
        start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("async reset outputs", 64'({busy, done, word_ready, lut_cs_n, lut_d}),
                     64'(5'b00010));
        check_output("shifts before reset", 64'(shift_cnt - base), 64'(exp_shifts));
        repeat (2) @(posedge clk);
        #1;
        check_output("no shift in reset", 64'(shift_cnt - base), 64'(exp_shifts));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        return;
      end
      if (exp_cs_low) exp_shifts++;
      handshake = word_valid && word_ready;
      @(posedge clk);
      #1;
      if (handshake) widx++;
    end
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
    check_output("shift count", 64'(shift_cnt - base), 64'(exp_shifts));
  endtask

  initial begin
    logic [63:0] tbl;
    int          sw, sl;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; word_in = 8'h00; word_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy/done/ready/cs_n/d", 64'({busy, done, word_ready, lut_cs_n, lut_d}),
                 64'(5'b00010));
`ifdef SLL_CRC_EN
    check_output("reset crc", 64'(crc), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // entry i = i, continuous valid
    for (int i = 0; i < 16; i++) tbl[4*i +: 4] = 4'(i);
    run_load(tbl, -1, 0, -1, -1, -1);
    for (int i = 0; i < 16; i++) check_output($sformatf("lut entry %0d", i), 64'(lut_sr[4*i +: 4]), 64'(i));
    repeat (2) @(posedge clk);
    #1;

    // stall before word 3
    tbl = {$urandom, $urandom};
    run_load(tbl, 3, 5, -1, -1, -1);
    check_output("table after stall", lut_sr, tbl);
    repeat (2) @(posedge clk);
    #1;

    // abort mid-SHIFT, then a clean reload
    tbl = {$urandom, $urandom};
    run_load(tbl, -1, 0, 30, -1, -1);
    repeat (2) @(posedge clk);
    #1;
    tbl = {$urandom, $urandom};
    run_load(tbl, -1, 0, -1, -1, -1);
    check_output("table after abort+reload", lut_sr, tbl);
    repeat (2) @(posedge clk);
    #1;

    // second start while busy is ignored
    tbl = {$urandom, $urandom};
    run_load(tbl, -1, 0, -1, 10, -1);
    check_output("table with double start", lut_sr, tbl);
    repeat (2) @(posedge clk);
    #1;

    // reset mid-SHIFT, then reload
    tbl = {$urandom, $urandom};
    run_load(tbl, -1, 0, -1, -1, 40);
    repeat (2) @(posedge clk);
    #1;
    tbl = {$urandom, $urandom};
    run_load(tbl, -1, 0, -1, -1, -1);
    check_output("table after reset+reload", lut_sr, tbl);
    repeat (2) @(posedge clk);
    #1;

    // all-zero table
    run_load(64'h0, -1, 0, -1, -1, -1);
    check_output("zero table", lut_sr, 64'h0);
`ifdef SLL_CRC_EN
    check_output("crc zero table", 64'(crc), 64'h0);
`endif
    repeat (2) @(posedge clk);
    #1;

    // random tables with a random stall
    for (int r = 0; r < 3; r++) begin
      tbl = {$urandom, $urandom};
      sw  = int'($urandom_range(0, 7));
      sl  = int'($urandom_range(1, 6));
      run_load(tbl, sw, sl, -1, -1, -1);
      check_output($sformatf("random table %0d", r), lut_sr, tbl);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
